// File: rtl/regfile_sb.sv
// Parametrised register file with per-byte writes, same-cycle write bypass and a
// write-pending scoreboard so the issue stage can stall on RAW hazards.
module regfile_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NRD    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NRD*ADDR_W-1:0]    RA,
  output logic [NRD*DATA_W-1:0]    R,
  output logic [NRD-1:0]           Busy,
  input  logic [ADDR_W-1:0]        WA,
  input  logic [DATA_W-1:0]        Din,
  input  logic                     WE,
  input  logic [DATA_W/8-1:0]      BE,
  input  logic                     SetVld,
  input  logic [ADDR_W-1:0]        SetAddr,
  output logic                     AnyBusy
);

  localparam int unsigned Depth = 1 << ADDR_W;
  localparam int unsigned NB    = DATA_W / 8;

  logic [DATA_W-1:0] regs [Depth];
  logic [Depth-1:0]  sb_q;
  logic [Depth-1:0]  sb_d;
  logic              wr_en;
  logic              set_en;
  logic [DATA_W-1:0] wr_old;
  logic [DATA_W-1:0] wr_merge;

  // Writes are ignored during reset so the bypass path also reads zero then.
  assign wr_en  = WE & rst_n & (WA != '0);
  assign set_en = SetVld & (SetAddr != '0);
  assign wr_old = regs[WA];

  always_comb begin
    wr_merge = wr_old;
    for (int unsigned k = 0; k < NB; k++) begin
      if (BE[k]) begin
        wr_merge[8*k +: 8] = Din[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[WA] <= wr_merge;
    end
  end

  // Set is applied after clear so a newly issued producer wins a collision.
  always_comb begin
    sb_d = sb_q;
    if (wr_en) begin
      sb_d[WA] = 1'b0;
    end
    if (set_en) begin
      sb_d[SetAddr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  assign AnyBusy = |sb_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;

    assign ra  = RA[i*ADDR_W +: ADDR_W];
    assign hit = wr_en & (WA == ra);

    assign R[i*DATA_W +: DATA_W] = (ra == '0) ? '0 :
                                   hit        ? wr_merge : regs[ra];
    assign Busy[i] = sb_q[ra] & ~hit;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed bench for regfile_sb; a 2-port and a 4-port instance share
// stimulus and are compared against an array-based reference model.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] ra4;
  logic [4:0]  wa;
  logic [31:0] din;
  logic        we;
  logic [3:0]  be;
  logic        setvld;
  logic [4:0]  setaddr;

  logic [127:0] r4;
  logic [3:0]   busy4;
  logic         anybusy4;
  logic [63:0]  r2;
  logic [1:0]   busy2;
  logic         anybusy2;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl_regs [32];
  logic [31:0] mdl_sb;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NRD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .RA(ra4), .R(r4), .Busy(busy4), .WA(wa), .Din(din),
    .WE(we), .BE(be), .SetVld(setvld), .SetAddr(setaddr), .AnyBusy(anybusy4)
  );

  regfile_sb dut2 (
    .clk(clk), .rst_n(rst_n), .RA(ra4[9:0]), .R(r2), .Busy(busy2), .WA(wa), .Din(din),
    .WE(we), .BE(be), .SetVld(setvld), .SetAddr(setaddr), .AnyBusy(anybusy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merged(input logic [31:0] old);
    logic [31:0] v = old;
    for (int k = 0; k < 4; k++) if (be[k]) v[8*k +: 8] = din[8*k +: 8];
    return v;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (!rst_n || a == 0) return 32'h0;
    if (we && wa == a) return merged(mdl_regs[a]);
    return mdl_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (!rst_n) return 1'b0;
    return mdl_sb[a] && !(we && wa == a && wa != 0);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mdl_regs[i] = 32'h0;
    mdl_sb = 32'h0;
  endtask

  task automatic model_step();
    if (!rst_n) return;
    if (we && wa != 0) begin
      mdl_regs[wa] = merged(mdl_regs[wa]);
      mdl_sb[wa]   = 1'b0;
    end
    if (setvld && setaddr != 0) mdl_sb[setaddr] = 1'b1;
  endtask

  task automatic check_all(input string tag);
    logic [4:0] a;
    for (int p = 0; p < 4; p++) begin
      a = ra4[p*5 +: 5];
      check($sformatf("%s r4[%0d] ra=%0d", tag, p, a), r4[p*32 +: 32], exp_read(a));
      check($sformatf("%s busy4[%0d] ra=%0d", tag, p, a), 32'(busy4[p]), 32'(exp_busy(a)));
    end
    for (int p = 0; p < 2; p++) begin
      a = ra4[p*5 +: 5];
      check($sformatf("%s r2[%0d] ra=%0d", tag, p, a), r2[p*32 +: 32], exp_read(a));
      check($sformatf("%s busy2[%0d] ra=%0d", tag, p, a), 32'(busy2[p]), 32'(exp_busy(a)));
    end
    check({tag, " anybusy4"}, 32'(anybusy4), 32'(|mdl_sb));
    check({tag, " anybusy2"}, 32'(anybusy2), 32'(|mdl_sb));
  endtask

  task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [4:0] a3);
    ra4 = {a3, a2, a1, a0};
  endtask

  task automatic idle();
    we = 1'b0; be = 4'h0; setvld = 1'b0; setaddr = 5'd0; wa = 5'd0; din = 32'h0;
  endtask

  // Check combinational outputs mid-cycle.
  task automatic settle(input string tag);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [4:0] rand_addr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  task automatic rand_inputs();
    we = 1'($urandom); wa = rand_addr(); din = $urandom; be = 4'($urandom);
    setvld = 1'($urandom); setaddr = rand_addr();
    set_ra(rand_addr(), rand_addr(), rand_addr(), rand_addr());
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    set_ra(0, 1, 2, 3);
    model_clear();
    #1;
    check_all("init_rst");
    #20;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Random prefill.
    for (int c = 0; c < 60; c++) begin
      rand_inputs();
      settle("prefill");
      tick();
    end

    // Mid-operation reset pulse with a write pending at the edge.
    rand_inputs();
    we = 1'b1; wa = 5'd6;
    rst_n = 1'b0;
    model_clear();
    #1;
    check("rst_now r0", r4[31:0], 32'h0);
    check("rst_now anybusy", 32'(anybusy4), 32'h0);
    settle("rst_low");
    tick();
    rst_n = 1'b1;
    idle();
    for (int g = 0; g < 8; g++) begin
      set_ra(5'(4*g), 5'(4*g + 1), 5'(4*g + 2), 5'(4*g + 3));
      settle("post_rst");
      for (int p = 0; p < 4; p++) check($sformatf("post_rst zero p%0d", p), r4[p*32 +: 32], 32'h0);
      tick();
    end

    // Write with same-cycle bypass.
    we = 1'b1; wa = 5'd5; din = 32'hDEADBEEF; be = 4'hF; set_ra(5, 0, 5, 1);
    settle("byp5");
    check("byp5 const", r4[31:0], 32'hDEADBEEF);
    tick();
    idle();
    settle("rd5");
    check("rd5 const", r4[31:0], 32'hDEADBEEF);
    tick();

    // Byte enables.
    we = 1'b1; wa = 5'd7; din = 32'h11223344; be = 4'hF; set_ra(7, 7, 7, 7);
    settle("be_init");
    tick();
    din = 32'hAABBCCDD; be = 4'b0101;
    settle("be_byp");
    check("be_byp const", r4[31:0], 32'h11BB33DD);
    tick();
    idle();
    settle("be_rd");
    check("be_rd const", r4[31:0], 32'h11BB33DD);
    tick();

    // Register 0 is immutable and never busy.
    we = 1'b1; wa = 5'd0; din = 32'hFFFFFFFF; be = 4'hF; setvld = 1'b1; setaddr = 5'd0;
    set_ra(0, 0, 0, 0);
    settle("r0_wr");
    check("r0_wr const", r4[31:0], 32'h0);
    check("r0_wr busy", 32'(busy4[0]), 32'h0);
    tick();
    idle();
    settle("r0_next");
    check("r0_next const", r4[31:0], 32'h0);
    check("r0_next anybusy", 32'(anybusy4), 32'h0);
    tick();

    // Scoreboard lifecycle for reg 9.
    setvld = 1'b1; setaddr = 5'd9; set_ra(9, 9, 9, 9);
    settle("sb9_set");
    check("sb9_set busy", 32'(busy4[0]), 32'h0);
    tick();
    idle();
    settle("sb9_pend");
    check("sb9_pend busy", 32'(busy4[0]), 32'h1);
    check("sb9_pend anybusy", 32'(anybusy4), 32'h1);
    tick();
    we = 1'b1; wa = 5'd9; din = 32'hCAFEF00D; be = 4'hF;
    settle("sb9_wr");
    check("sb9_wr busy", 32'(busy4[0]), 32'h0);
    check("sb9_wr byp", r4[31:0], 32'hCAFEF00D);
    tick();
    idle();
    settle("sb9_done");
    check("sb9_done anybusy", 32'(anybusy4), 32'h0);
    tick();

    // Set/clear collision on reg 3, four independent read ports.
    setvld = 1'b1; setaddr = 5'd3;
    settle("col_pre");
    tick();
    setvld = 1'b1; setaddr = 5'd3; we = 1'b1; wa = 5'd3; din = 32'h12345678; be = 4'hF;
    set_ra(3, 9, 7, 5);
    settle("col");
    check("col busy", 32'(busy4[0]), 32'h0);
    check("col p0", r4[31:0], 32'h12345678);
    check("col p1", r4[63:32], 32'hCAFEF00D);
    check("col p2", r4[95:64], 32'h11BB33DD);
    check("col p3", r4[127:96], 32'hDEADBEEF);
    tick();
    idle();
    settle("col_next");
    check("col_next busy", 32'(busy4[0]), 32'h1);
    check("col_next anybusy", 32'(anybusy4), 32'h1);
    tick();

    // Clear and set to different addresses both land.
    we = 1'b1; wa = 5'd3; din = 32'h0BADF00D; be = 4'hF; setvld = 1'b1; setaddr = 5'd4;
    set_ra(3, 4, 0, 0);
    settle("diff");
    tick();
    idle();
    settle("diff_next");
    check("diff_next busy3", 32'(busy4[0]), 32'h0);
    check("diff_next busy4", 32'(busy4[1]), 32'h1);
    tick();

    // Long random run with occasional reset pulses.
    for (int c = 0; c < 600; c++) begin
      rand_inputs();
      rst_n = ($urandom_range(0, 59) != 0);
      if (!rst_n) model_clear();
      settle("rand");
      tick();
      rst_n = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with a write-pending scoreboard, for the pipelined CPU datapath. It is the successor to the fixed 32x32, two-read-port register file. It adds configurable width, depth and read-port count, a real reset, per-byte write enables, and same-cycle write-to-read bypass. It also tracks which registers have an in-flight producer, so the issue stage can stall on RAW hazards without its own tracking logic.

## Interface
- DATA_W, 32, register width in bits; multiple of 8
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NRD, 2, number of read ports, 1..4
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- RA  in  NRD*ADDR_W  read addresses; port i = RA[i*ADDR_W +: ADDR_W]
- R  out  NRD*DATA_W  read data; port i = R[i*DATA_W +: DATA_W]
- Busy  out  NRD  bit i = register RA port i has a pending producer, not resolved this cycle
- WA  in  ADDR_W  write address
- Din  in  DATA_W  write data
- WE  in  1  write enable
- BE  in  DATA_W/8  byte enables for the write; bit k covers Din[8k+7:8k]
- SetVld  in  1  issue stage marks register SetAddr as pending
- SetAddr  in  ADDR_W  register to mark pending
- AnyBusy  out  1  OR of all scoreboard bits, for drain/flush checks

## Operation
- Storage: 2**ADDR_W words of DATA_W bits, plus a scoreboard vector sb of 2**ADDR_W bits.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes to it are dropped.
  - SetVld with SetAddr=0 is ignored.
- Write: on a rising edge with WE=1 and WA!=0, byte k of regs[WA] takes Din byte k where BE[k]=1; the other bytes are held. Any WE=1 to WA!=0 clears sb[WA], including WE=1 with BE=0.
- Set: on a rising edge with SetVld=1 and SetAddr!=0, sb[SetAddr] <= 1.
- Set and clear to the same address in the same cycle: set wins and sb stays 1, because a new producer was issued. Set and clear to different addresses both take effect.
- Read (combinational, per port i):
  - RA=0 gives R=0.
  - Otherwise, if WE=1 and WA==RA, R is the byte merge of Din (where BE=1) and regs[RA] (where BE=0). This is the bypass.
  - Otherwise R=regs[RA].
- Busy (combinational, per port i):
  - Busy[i] = sb[RA_i] & ~(WE & WA==RA_i & WA!=0).
  - A write in the current cycle resolves the hazard for readers in the same cycle.
  - SetVld in the current cycle does not affect Busy until the next cycle.
- AnyBusy = |sb (registered state only, no bypass term).
- Reset: while rst_n=0, all regs clear to 0 and sb clears to 0, asynchronously.
  - R then reads 0 on every port, Busy=0 and AnyBusy=0.
  - WE and SetVld are ignored while rst_n=0.
  - Reset asserted mid-operation discards any same-edge write.

## Timing
- Read latency: 0 cycles, purely combinational from RA, WA, WE, BE and Din.
- Write latency: 1 edge; the data is visible from stored state in the cycle after the edge, and via bypass in the same cycle.
- Scoreboard set latency: 1 edge. A reader issued in the same cycle as the set sees Busy=0 for that register.
- Scoreboard clear: the clear is registered at the edge, but Busy drops in the same cycle WE is asserted.
- Reset deassertion is synchronised externally. The first write edge is the first rising clk edge after rst_n rises.
- No multi-cycle paths. All outputs depend only on sb, regs and the current inputs.

## Test plan
- Reset: after a random prefill, pulse rst_n low between clock edges -> R=0 on all ports, Busy=0 and AnyBusy=0 immediately; reading regs 1..31 afterwards returns 0.
- Write then read, with bypass:
  - WE=1, WA=5, Din=0xDEADBEEF, BE=4'hF, RA port0=5 in the same cycle -> R0=0xDEADBEEF before the edge.
  - Next cycle with WE=0 -> R0=0xDEADBEEF.
- Byte enables: regs[7]=0x11223344, then write Din=0xAABBCCDD with BE=4'b0101 -> bypass and the following cycle read 0x11BB33DD.
- Register 0: WE=1, WA=0, Din=0xFFFFFFFF; SetVld=1, SetAddr=0 -> R for RA=0 is 0 in that cycle and the next; Busy=0 and AnyBusy=0.
- Scoreboard lifecycle for reg 9:
  - SetVld for reg 9 -> Busy for RA=9 is 0 in the set cycle, 1 the next cycle, and AnyBusy=1.
  - WE to 9 -> Busy=0 in the write cycle and R shows the bypassed data.
  - Next cycle -> AnyBusy=0.
- Set/clear collision: sb[3]=1, then in the same cycle WE=1 with WA=3 and SetVld=1 with SetAddr=3 -> Busy for RA=3 is 0 that cycle, and Busy=1 and AnyBusy=1 the next cycle. Repeat with NRD=4, checking that all four ports read independent addresses correctly.
